// File: rtl/gpio_irq_io_pkg.sv
// Shared constants and helpers for the GPIO interrupt controller.
package gpio_irq_io_pkg;

  localparam int CE_WIDTH = 6;

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_IN    = 3'd2;
  localparam logic [2:0] REG_IEN   = 3'd3;
  localparam logic [2:0] REG_ISTAT = 3'd4;
  localparam logic [2:0] REG_CFG   = 3'd5;

  localparam int CFG_GIE_BIT  = 0;
  localparam int CFG_EDGE_LSB = 1;
  localparam int CFG_EDGE_MSB = 2;
  localparam int CFG_WIDTH    = 3;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // True when exactly one chip-enable bit is set.
  function automatic logic is_onehot(input logic [CE_WIDTH-1:0] ce);
    int n;
    n = 0;
    for (int i = 0; i < CE_WIDTH; i++) begin
      if (ce[i]) n++;
    end
    return (n == 1);
  endfunction

  // CE bit 5 selects register 0, bit 0 selects register 5.
  function automatic logic [2:0] ce_index(input logic [CE_WIDTH-1:0] ce);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < CE_WIDTH; i++) begin
      if (ce[i]) idx = 3'(CE_WIDTH - 1 - i);
    end
    return idx;
  endfunction

  // Replace only the byte lanes enabled by be.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_irq_io_debounce.sv
// One-bit input conditioner: 2-FF synchroniser followed by a stability counter.
module gpio_debounce
  #(parameter int DEB_CYCLES = 50000)
  (input  logic clk,
   input  logic reset,
   input  logic pin_async,
   output logic stable);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic sync1, sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the pin into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin_async;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES clocks in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_irq_io.sv
// GPIO block with debounced inputs, edge interrupts and a one-hot CE register bus.
module gpio_irq_io
  import gpio_irq_io_pkg::*;
  #(parameter int GPIO_WIDTH = 13,
    parameter int DEB_CYCLES = 50000)
  (input  logic                  Bus2IP_Clk,
   input  logic                  Bus2IP_Reset,
   input  logic [31:0]           Bus2IP_Data,
   input  logic [3:0]            Bus2IP_BE,
   input  logic [CE_WIDTH-1:0]   Bus2IP_RdCE,
   input  logic [CE_WIDTH-1:0]   Bus2IP_WrCE,
   output logic [31:0]           IP2Bus_Data,
   output logic                  IP2Bus_RdAck,
   output logic                  IP2Bus_WrAck,
   output logic                  IP2Bus_Error,
   input  logic [GPIO_WIDTH-1:0] gpio_I,
   output logic [GPIO_WIDTH-1:0] gpio_O,
   output logic [GPIO_WIDTH-1:0] gpio_T,
   output logic                  irq);

  logic [CE_WIDTH-1:0]   rd_ce_q, wr_ce_q;
  logic                  rd_start, wr_start, both_ce, rd_fire, wr_fire, xfer_err, wr_commit;
  logic [2:0]            rd_idx, wr_idx;
  logic [GPIO_WIDTH-1:0] out_r, dir_r, ien_r, istat_r, in_stable, in_prev, edge_set, istat_clr;
  logic [GPIO_WIDTH-1:0] rise, fall;
  logic [CFG_WIDTH-1:0]  cfg_r;
  logic [31:0]           reg_view [8];
  logic [31:0]           wr_merged, clr_bytes, rd_value;
  logic [31:0]           rd_data_r;
  logic                  rd_ack_r, wr_ack_r, err_r, irq_r;
  logic                  unused_bits;

  genvar g;
  generate
    for (g = 0; g < GPIO_WIDTH; g++) begin : g_deb
      gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb
        (.clk(Bus2IP_Clk), .reset(Bus2IP_Reset), .pin_async(gpio_I[g]), .stable(in_stable[g]));
    end
  endgenerate

  // Detect new transfers on CE rising from zero and classify them as good or error.
  always_comb begin
    rd_start  = (Bus2IP_RdCE != '0) && (rd_ce_q == '0);
    wr_start  = (Bus2IP_WrCE != '0) && (wr_ce_q == '0);
    both_ce   = (Bus2IP_RdCE != '0) && (Bus2IP_WrCE != '0);
    rd_fire   = rd_start | (both_ce & wr_start);
    wr_fire   = wr_start | (both_ce & rd_start);
    rd_idx    = ce_index(Bus2IP_RdCE);
    wr_idx    = ce_index(Bus2IP_WrCE);
    xfer_err  = 1'b0;
    if (both_ce) begin
      xfer_err = rd_fire | wr_fire;
    end else begin
      xfer_err = (rd_fire & ~is_onehot(Bus2IP_RdCE)) |
                 (wr_fire & (~is_onehot(Bus2IP_WrCE) | (wr_idx == REG_IN)));
    end
    wr_commit = wr_fire & ~xfer_err;
  end

  // Zero-extended register views plus the byte-merged write value and W1C mask.
  always_comb begin
    reg_view[0] = 32'(out_r);
    reg_view[1] = 32'(dir_r);
    reg_view[2] = 32'(in_stable);
    reg_view[3] = 32'(ien_r);
    reg_view[4] = 32'(istat_r);
    reg_view[5] = 32'(cfg_r);
    reg_view[6] = '0;
    reg_view[7] = '0;
    rd_value    = reg_view[rd_idx];
    wr_merged   = byte_merge(reg_view[wr_idx], Bus2IP_Data, Bus2IP_BE);
    clr_bytes   = byte_merge(32'h0, Bus2IP_Data, Bus2IP_BE);
    istat_clr   = (wr_commit && (wr_idx == REG_ISTAT)) ? clr_bytes[GPIO_WIDTH-1:0] : '0;
  end

  assign unused_bits = ^{wr_merged, clr_bytes};

  // Edge selection on the debounced inputs against their previous value.
  always_comb begin
    rise     = in_stable & ~in_prev;
    fall     = ~in_stable & in_prev;
    edge_set = '0;
    case (edge_mode_e'(cfg_r[CFG_EDGE_MSB:CFG_EDGE_LSB]))
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      EDGE_BOTH: edge_set = rise | fall;
      default:   edge_set = '0;
    endcase
  end

  // Register file; a new edge wins over a simultaneous W1C on the same bit.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      out_r   <= '0;
      dir_r   <= '1;
      ien_r   <= '0;
      istat_r <= '0;
      cfg_r   <= '0;
      in_prev <= '0;
    end else begin
      in_prev <= in_stable;
      istat_r <= (istat_r & ~istat_clr) | edge_set;
      if (wr_commit) begin
        case (wr_idx)
          REG_OUT: out_r <= wr_merged[GPIO_WIDTH-1:0];
          REG_DIR: dir_r <= wr_merged[GPIO_WIDTH-1:0];
          REG_IEN: ien_r <= wr_merged[GPIO_WIDTH-1:0];
          REG_CFG: cfg_r <= wr_merged[CFG_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Bus handshake outputs and registered interrupt.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      rd_ce_q   <= '0;
      wr_ce_q   <= '0;
      rd_ack_r  <= 1'b0;
      wr_ack_r  <= 1'b0;
      err_r     <= 1'b0;
      rd_data_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      rd_ce_q   <= Bus2IP_RdCE;
      wr_ce_q   <= Bus2IP_WrCE;
      rd_ack_r  <= rd_fire;
      wr_ack_r  <= wr_fire;
      err_r     <= xfer_err;
      rd_data_r <= (rd_fire && !xfer_err) ? rd_value : '0;
      irq_r     <= cfg_r[CFG_GIE_BIT] & (|(istat_r & ien_r));
    end
  end

  assign IP2Bus_Data  = rd_data_r;
  assign IP2Bus_RdAck = rd_ack_r;
  assign IP2Bus_WrAck = wr_ack_r;
  assign IP2Bus_Error = err_r;
  assign gpio_O       = out_r;
  assign gpio_T       = dir_r;
  assign irq          = irq_r;

endmodule
